// File: rtl/pc_sequencer.sv
// Next-PC controller for the single-cycle MIPS core: boot, run, trap entry, halt/resume.
// Optional `SINGLE_STEP_EN adds a step input that advances one instruction while halted.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int unsigned BOOT_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        exception,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic [31:0] pc_next,
  output logic [31:0] epc,
  output logic        halted,
  output logic        in_trap,
  output logic        double_fault,
  output logic        addr_err,
  output logic        retire
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_TRAP, ST_HALT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_boot_cnt;
  logic [CNT_W-1:0]  w_boot_cnt_nxt;
  logic [31:0]       r_epc;
  logic [31:0]       w_epc_nxt;
  logic              r_double_fault;
  logic              w_double_fault_nxt;
  logic              r_addr_err;
  logic              w_addr_err_nxt;

  logic [31:0]       w_pc_plus4;
  logic [31:0]       w_br_target;
  logic [31:0]       w_j_target;
  logic              w_jr_misalign;

  logic [31:0]       w_run_pc;
  logic              w_run_retire;
  logic              w_run_trap;
  logic              w_run_halt;

  assign w_pc_plus4    = pc_cur + 32'd4;
  assign w_br_target   = w_pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign w_j_target    = {w_pc_plus4[31:28], jump_target, 2'b00};
  assign w_jr_misalign = jr && (jr_target[1:0] != 2'b00);

  // Prioritised RUN-style next-PC selection, shared by RUN and single-step
  always_comb begin
    w_run_pc     = w_pc_plus4;
    w_run_retire = 1'b1;
    w_run_trap   = 1'b0;
    w_run_halt   = 1'b0;
    if (exception || w_jr_misalign) begin
      w_run_pc     = EXC_VECTOR;
      w_run_retire = 1'b0;
      w_run_trap   = 1'b1;
    end else if (halt_req) begin
      w_run_pc     = pc_cur;
      w_run_retire = 1'b0;
      w_run_halt   = 1'b1;
    end else if (stall) begin
      w_run_pc     = pc_cur;
      w_run_retire = 1'b0;
    end else if (jr) begin
      w_run_pc = jr_target;
    end else if (jump) begin
      w_run_pc = w_j_target;
    end else if (branch_taken) begin
      w_run_pc = w_br_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_BOOT;
      r_boot_cnt     <= '0;
      r_epc          <= '0;
      r_double_fault <= 1'b0;
      r_addr_err     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_boot_cnt     <= w_boot_cnt_nxt;
      r_epc          <= w_epc_nxt;
      r_double_fault <= w_double_fault_nxt;
      r_addr_err     <= w_addr_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_boot_cnt_nxt     = r_boot_cnt;
    w_epc_nxt          = r_epc;
    w_double_fault_nxt = r_double_fault;
    w_addr_err_nxt     = r_addr_err;
    pc_next            = pc_cur;
    retire             = 1'b0;
    halted             = 1'b0;
    in_trap            = 1'b0;
    case (r_state)
      ST_BOOT: begin
        pc_next        = RESET_VECTOR;
        w_boot_cnt_nxt = r_boot_cnt + CNT_W'(1);
        if (r_boot_cnt == CNT_W'(BOOT_CYCLES - 1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        pc_next = w_run_pc;
        retire  = w_run_retire;
        if (w_run_trap) begin
          w_epc_nxt      = pc_cur;
          w_addr_err_nxt = r_addr_err | w_jr_misalign;
          w_state_nxt    = ST_TRAP;
        end else if (w_run_halt) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_TRAP: begin
        in_trap = 1'b1;
        // A second exception during the flush slot is unrecoverable
        if (exception) begin
          w_double_fault_nxt = 1'b1;
          w_state_nxt        = ST_HALT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (resume) begin
          w_state_nxt = ST_RUN;
        end
`ifdef SINGLE_STEP_EN
        else if (step) begin
          pc_next = w_run_pc;
          retire  = w_run_retire;
          if (w_run_trap) begin
            w_epc_nxt      = pc_cur;
            w_addr_err_nxt = r_addr_err | w_jr_misalign;
            w_state_nxt    = ST_TRAP;
          end
        end
`endif
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  assign epc          = r_epc;
  assign double_fault = r_double_fault;
  assign addr_err     = r_addr_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic vs a reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_VEC = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC = 32'h8000_0180;
  localparam int BOOT_N = 2;
  localparam int M_BOOT = 0, M_RUN = 1, M_TRAP = 2, M_HALT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_cur;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        stall, halt_req, resume, exception;
  logic        step = 1'b0;
  logic [31:0] pc_next, epc;
  logic        halted, in_trap, double_fault, addr_err, retire;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur),
    .branch_taken(branch_taken), .branch_imm(branch_imm),
    .jump(jump), .jump_target(jump_target), .jr(jr), .jr_target(jr_target),
    .stall(stall), .halt_req(halt_req), .resume(resume), .exception(exception),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .pc_next(pc_next), .epc(epc), .halted(halted), .in_trap(in_trap),
    .double_fault(double_fault), .addr_err(addr_err), .retire(retire)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state and per-cycle expectations
  int          m_mode, m_boot, n_mode, n_boot;
  logic [31:0] m_epc, n_epc;
  logic        m_df, m_ae, n_df, n_ae;
  logic [31:0] e_pc;
  logic        e_ret;

  task automatic clear_inputs();
    branch_taken = 0; branch_imm = '0; jump = 0; jump_target = '0;
    jr = 0; jr_target = '0; stall = 0; halt_req = 0; resume = 0; exception = 0;
  endtask

  task automatic model_reset();
    m_mode = M_BOOT; m_boot = 0; m_epc = '0; m_df = 0; m_ae = 0;
  endtask

  task automatic model_eval();
    logic [31:0] p4;
    int off;
    p4  = pc_cur + 32'd4;
    off = int'($signed(branch_imm));
    n_mode = m_mode; n_boot = m_boot; n_epc = m_epc; n_df = m_df; n_ae = m_ae;
    e_pc = pc_cur; e_ret = 0;
    if (m_mode == M_BOOT) begin
      e_pc = RST_VEC;
      n_boot = m_boot + 1;
      if (n_boot == BOOT_N) n_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (exception || (jr && (jr_target % 4) != 0)) begin
        e_pc = EXC_VEC; n_epc = pc_cur; n_mode = M_TRAP;
        if (jr && (jr_target % 4) != 0) n_ae = 1;
      end else if (halt_req) begin
        n_mode = M_HALT;
      end else if (!stall) begin
        e_ret = 1;
        if (jr) e_pc = jr_target;
        else if (jump) e_pc = (p4 & 32'hF000_0000) | (32'(jump_target) * 4);
        else if (branch_taken) e_pc = p4 + 32'(off * 4);
        else e_pc = p4;
      end
    end else if (m_mode == M_TRAP) begin
      if (exception) begin n_df = 1; n_mode = M_HALT; end
      else n_mode = M_RUN;
    end else begin
      if (resume) n_mode = M_RUN;
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    m_mode = n_mode; m_boot = n_boot; m_epc = n_epc; m_df = n_df; m_ae = n_ae;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    pc_cur = 32'h1234_5678;
    reset = 1;
    model_reset();
    #1;
    n_checks++; if (pc_next !== RST_VEC) begin n_errors++; $display("FAIL reset_pc_next: got %h expected %h", pc_next, RST_VEC); end
    n_checks++; if (retire !== 1'b0) begin n_errors++; $display("FAIL reset_retire: got %b expected 0", retire); end
    n_checks++; if (halted !== 1'b0 || in_trap !== 1'b0) begin n_errors++; $display("FAIL reset_flags: halted %b in_trap %b expected 0 0", halted, in_trap); end
    n_checks++; if (epc !== 32'h0 || double_fault !== 1'b0 || addr_err !== 1'b0) begin n_errors++; $display("FAIL reset_regs: epc %h df %b ae %b expected 0", epc, double_fault, addr_err); end
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < BOOT_N; i++) begin
      pc_cur = 32'h0;
      settle();
      n_checks++; if (pc_next !== RST_VEC || retire !== 1'b0) begin n_errors++; $display("FAIL boot_%0d: pc_next %h retire %b expected %h 0", i, pc_next, retire, RST_VEC); end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      pc_cur = 32'(i * 4);
      settle();
      n_checks++; if (pc_next !== 32'(i * 4 + 4) || retire !== 1'b1) begin n_errors++; $display("FAIL seq_%0d: pc_next %h retire %b expected %h 1", i, pc_next, retire, 32'(i * 4 + 4)); end
      tick();
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    pc_cur = 32'h0040_0010; branch_taken = 1; branch_imm = 16'hFFFC;
    settle();
    n_checks++; if (pc_next !== 32'h0040_0004 || retire !== 1'b1) begin n_errors++; $display("FAIL branch_back: pc_next %h retire %b expected 00400004 1", pc_next, retire); end
    n_checks++; if (pc_next !== e_pc) begin n_errors++; $display("FAIL branch_back_model: got %h expected %h", pc_next, e_pc); end
    tick();
    pc_cur = 32'h0040_0010; branch_imm = 16'h0003;
    settle();
    n_checks++; if (pc_next !== 32'h0040_0020) begin n_errors++; $display("FAIL branch_fwd: got %h expected 00400020", pc_next); end
    tick();
    // jump and jr both lose to a branch? no: jump beats branch
    pc_cur = 32'h0040_0010; jump = 1; jump_target = 26'h0000040;
    settle();
    n_checks++; if (pc_next !== 32'h0000_0100) begin n_errors++; $display("FAIL prio_jump_over_branch: got %h expected 00000100", pc_next); end
    tick();
  endtask

  task automatic test_jump_jr();
    clear_inputs();
    pc_cur = 32'h1040_0000; jump = 1; jump_target = 26'h0000100;
    settle();
    n_checks++; if (pc_next !== 32'h1000_0400 || retire !== 1'b1) begin n_errors++; $display("FAIL jump: pc_next %h retire %b expected 10000400 1", pc_next, retire); end
    tick();
    clear_inputs();
    pc_cur = 32'h1040_0000; jr = 1; jr_target = 32'h0040_0002;
    settle();
    n_checks++; if (pc_next !== EXC_VEC || retire !== 1'b0) begin n_errors++; $display("FAIL jr_misalign: pc_next %h retire %b expected %h 0", pc_next, retire, EXC_VEC); end
    tick();
    clear_inputs();
    pc_cur = EXC_VEC;
    settle();
    n_checks++; if (in_trap !== 1'b1 || pc_next !== EXC_VEC) begin n_errors++; $display("FAIL jr_trap: in_trap %b pc_next %h expected 1 %h", in_trap, pc_next, EXC_VEC); end
    n_checks++; if (epc !== 32'h1040_0000 || addr_err !== 1'b1) begin n_errors++; $display("FAIL jr_epc: epc %h addr_err %b expected 10400000 1", epc, addr_err); end
    tick();
    settle();
    n_checks++; if (in_trap !== 1'b0 || pc_next !== EXC_VEC + 32'd4 || retire !== 1'b1) begin n_errors++; $display("FAIL trap_exit: in_trap %b pc_next %h expected 0 %h", in_trap, pc_next, EXC_VEC + 32'd4); end
    tick();
    jr = 1; jr_target = 32'h0040_1000; pc_cur = EXC_VEC + 32'd4;
    settle();
    n_checks++; if (pc_next !== 32'h0040_1000 || addr_err !== 1'b1) begin n_errors++; $display("FAIL jr_aligned: pc_next %h addr_err %b expected 00401000 1", pc_next, addr_err); end
    tick();
  endtask

  task automatic test_exception();
    clear_inputs();
    pc_cur = 32'h0040_0020; exception = 1;
    settle();
    n_checks++; if (pc_next !== EXC_VEC || retire !== 1'b0) begin n_errors++; $display("FAIL exc_entry: pc_next %h retire %b expected %h 0", pc_next, retire, EXC_VEC); end
    tick();
    pc_cur = EXC_VEC;
    settle();
    n_checks++; if (in_trap !== 1'b1 || epc !== 32'h0040_0020) begin n_errors++; $display("FAIL exc_trap: in_trap %b epc %h expected 1 00400020", in_trap, epc); end
    n_checks++; if (double_fault !== 1'b0) begin n_errors++; $display("FAIL exc_df_early: got %b expected 0", double_fault); end
    tick();
    settle();
    n_checks++; if (halted !== 1'b1 || double_fault !== 1'b1 || epc !== 32'h0040_0020) begin n_errors++; $display("FAIL double_fault: halted %b df %b epc %h expected 1 1 00400020", halted, double_fault, epc); end
    n_checks++; if (pc_next !== EXC_VEC) begin n_errors++; $display("FAIL df_hold: got %h expected %h", pc_next, EXC_VEC); end
    tick();
    settle();
    n_checks++; if (halted !== 1'b1 || in_trap !== 1'b0) begin n_errors++; $display("FAIL halt_ignores_exc: halted %b in_trap %b expected 1 0", halted, in_trap); end
    tick();
    exception = 0; resume = 1;
    settle();
    tick();
    resume = 0;
    settle();
    n_checks++; if (halted !== 1'b0 || pc_next !== EXC_VEC + 32'd4 || retire !== 1'b1) begin n_errors++; $display("FAIL exc_resume: halted %b pc_next %h expected 0 %h", halted, pc_next, EXC_VEC + 32'd4); end
    tick();
  endtask

  task automatic test_halt();
    clear_inputs();
    pc_cur = 32'h0040_0100; halt_req = 1; branch_taken = 1; branch_imm = 16'h0010;
    settle();
    n_checks++; if (pc_next !== 32'h0040_0100 || retire !== 1'b0) begin n_errors++; $display("FAIL halt_req: pc_next %h retire %b expected 00400100 0", pc_next, retire); end
    tick();
    halt_req = 0;
    for (int i = 0; i < 10; i++) begin
      settle();
      n_checks++; if (halted !== 1'b1 || pc_next !== 32'h0040_0100 || retire !== 1'b0) begin n_errors++; $display("FAIL halt_hold_%0d: halted %b pc_next %h retire %b", i, halted, pc_next, retire); end
      tick();
    end
    resume = 1; halt_req = 1;
    settle();
    tick();
    clear_inputs();
    settle();
    n_checks++; if (halted !== 1'b0 || pc_next !== 32'h0040_0104 || retire !== 1'b1) begin n_errors++; $display("FAIL resume_wins: halted %b pc_next %h retire %b expected 0 00400104 1", halted, pc_next, retire); end
    tick();
  endtask

  task automatic test_stall_reset();
    clear_inputs();
    pc_cur = 32'h0040_0200; stall = 1; branch_taken = 1; branch_imm = 16'h0005;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++; if (pc_next !== 32'h0040_0200 || retire !== 1'b0) begin n_errors++; $display("FAIL stall_%0d: pc_next %h retire %b expected 00400200 0", i, pc_next, retire); end
      tick();
    end
    n_checks++; if (epc !== 32'h0040_0020) begin n_errors++; $display("FAIL pre_reset_epc: got %h expected 00400020", epc); end
    #2;
    reset = 1;
    model_reset();
    #1;
    n_checks++; if (pc_next !== RST_VEC || epc !== 32'h0) begin n_errors++; $display("FAIL async_reset: pc_next %h epc %h expected %h 0", pc_next, epc, RST_VEC); end
    n_checks++; if (double_fault !== 1'b0 || addr_err !== 1'b0 || halted !== 1'b0) begin n_errors++; $display("FAIL async_reset_flags: df %b ae %b halted %b expected 0", double_fault, addr_err, halted); end
    @(negedge clk);
    reset = 0;
    clear_inputs();
  endtask

  task automatic test_random();
    logic [31:0] prev;
    prev = RST_VEC;
    for (int i = 0; i < 600; i++) begin
      exception    = ($urandom_range(0, 19) == 0);
      halt_req     = ($urandom_range(0, 14) == 0);
      resume       = ($urandom_range(0, 2) == 0);
      stall        = ($urandom_range(0, 5) == 0);
      jr           = ($urandom_range(0, 4) == 0);
      jr_target    = $urandom() & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      jump         = ($urandom_range(0, 3) == 0);
      jump_target  = 26'($urandom());
      branch_taken = ($urandom_range(0, 2) == 0);
      branch_imm   = 16'($urandom());
      pc_cur       = ($urandom_range(0, 9) == 0) ? ($urandom() & 32'hFFFF_FFFC) : prev;
      if ($urandom_range(0, 149) == 0) begin
        #3;
        reset = 1;
        model_reset();
        #1;
        n_checks++; if (pc_next !== RST_VEC || epc !== 32'h0) begin n_errors++; $display("FAIL rnd_reset_%0d: pc_next %h epc %h", i, pc_next, epc); end
        @(negedge clk);
        reset = 0;
        prev = RST_VEC;
        continue;
      end
      settle();
      n_checks++; if (pc_next !== e_pc) begin n_errors++; $display("FAIL rnd_pc_next_%0d: got %h expected %h", i, pc_next, e_pc); end
      n_checks++; if (retire !== e_ret) begin n_errors++; $display("FAIL rnd_retire_%0d: got %b expected %b", i, retire, e_ret); end
      n_checks++; if (halted !== (m_mode == M_HALT) || in_trap !== (m_mode == M_TRAP)) begin n_errors++; $display("FAIL rnd_state_%0d: halted %b in_trap %b mode %0d", i, halted, in_trap, m_mode); end
      n_checks++; if (epc !== m_epc || double_fault !== m_df || addr_err !== m_ae) begin n_errors++; $display("FAIL rnd_regs_%0d: epc %h df %b ae %b expected %h %b %b", i, epc, double_fault, addr_err, m_epc, m_df, m_ae); end
      prev = e_pc;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump_jr();
    test_exception();
    test_halt();
    test_stall_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller that sequences the program counter register in the single-cycle MIPS core. Each cycle it computes pc_next, which the PC register captures, from the current PC, branch/jump/jr controls, stall, halt and exception inputs. It owns the boot sequence, exception entry (EPC capture), halt/resume and misaligned-jr detection.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value driven during BOOT and after reset
EXC_VECTOR, 32'h8000_0180, exception entry address
BOOT_CYCLES, 2, cycles spent in BOOT before entering RUN (1..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
pc_cur  input  32  current PC register output
branch_taken  input  1  conditional branch resolved taken
branch_imm  input  16  branch immediate (word offset, signed)
jump  input  1  J/JAL
jump_target  input  26  instr_index field
jr  input  1  JR/JALR
jr_target  input  32  register-sourced target
stall  input  1  hold PC this cycle
halt_req  input  1  request halt
resume  input  1  leave HALT
exception  input  1  external exception request
pc_next  output  32  value to PC register input
epc  output  32  PC of faulting instruction
halted  output  1  state == HALT
in_trap  output  1  state == TRAP
double_fault  output  1  sticky, exception taken while in TRAP
addr_err  output  1  sticky, misaligned jr target seen
retire  output  1  pulse: PC advanced in RUN

Behaviour:
- Reset (async): state=BOOT, boot counter=0, epc=0, double_fault=0, addr_err=0; pc_next=RESET_VECTOR, retire=0, halted=0, in_trap=0.
- States BOOT, RUN, TRAP, HALT, one-hot or binary, registered; pc_next, retire, halted, in_trap are combinational from state and inputs (zero added latency; PC updates at the same edge).
- pc_plus4 = pc_cur + 4, mod 2^32.
- Branch target = pc_plus4 + (sign_extend(branch_imm) << 2), mod 2^32, no overflow flag.
- Jump target = {pc_plus4[31:28], jump_target, 2'b00}.
- BOOT: pc_next=RESET_VECTOR; counter increments each cycle; at count == BOOT_CYCLES-1 -> RUN. All other inputs ignored.
- RUN priority (highest first):
  1. exception, or jr with jr_target[1:0] != 0: pc_next=EXC_VECTOR; epc<=pc_cur; addr_err<=1 if misaligned jr; -> TRAP; retire=0.
  2. halt_req: pc_next=pc_cur; -> HALT; retire=0.
  3. stall: pc_next=pc_cur; stay RUN; retire=0.
  4. jr: pc_next=jr_target. 5. jump: jump target. 6. branch_taken: branch target. 7. else pc_plus4.
  Cases 4-7 assert retire=1.
- Multiple of jr/jump/branch_taken asserted: priority above applies, no error.
- TRAP (exactly 1 cycle, pipeline flush slot): pc_next=pc_cur (holds EXC_VECTOR); -> RUN. If exception asserted in TRAP: double_fault<=1, -> HALT, epc unchanged.
- HALT: pc_next=pc_cur; resume -> RUN (resume wins over simultaneous halt_req); exception ignored in HALT.
- double_fault and addr_err are sticky until reset.
- Reset mid-operation in any state: immediate return to BOOT state values; epc cleared.

Optional Feature:
SINGLE_STEP_EN: adds input step (1 bit). When defined: in HALT, a step pulse (without resume) performs exactly one RUN-style next-PC computation (same priority list; exception path enters TRAP) and returns to HALT the following cycle with retire=1 for that one cycle; step held high advances one instruction per cycle. When undefined: port absent, HALT leaves only via resume or reset.

Test Plan:
- Reset, BOOT_CYCLES=2: pc_next=0 for 2 cycles, then 0,4,8,... with retire=1 each cycle.
- pc_cur=0x00400010, branch_taken, branch_imm=16'hFFFC -> pc_next=0x00400004; imm=0x0003 -> 0x00400020.
- pc_cur=0x1040_0000, jump, jump_target=26'h0000100 -> pc_next=0x1000_0400; jr with jr_target=0x00400002 -> pc_next=0x80000180, epc=0x10400000, addr_err=1, in_trap next cycle.
- exception at pc_cur=0x00400020 -> epc=0x00400020, TRAP one cycle; exception again in TRAP -> double_fault=1, halted=1.
- halt_req in RUN -> pc_next held for 10 cycles; resume+halt_req same cycle -> RUN, sequential advance resumes.
- stall 3 cycles with branch_taken asserted -> pc_next=pc_cur, retire=0; async reset asserted mid-stall -> pc_next=RESET_VECTOR immediately, epc=0.
